serial_div_qr: RTL and testbench

//  Parametrised radix-2 restoring serial divider. Produces one quotient bit per clock and returns

---
 rtl/serial_div_qr.sv | 145 ++++++++++++++
 tb/tb_serial_div_qr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_div_qr.sv
// Radix-2 restoring serial divider: one quotient bit per clock, optional signed
// mode, independent valid/ready handshakes on both operands and on the result.
module serial_div_qr #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic [WIDTH-1:0] x,
    input  logic             sgn,
    input  logic             data_x_vld,
    output logic             data_x_rdy,
    input  logic [WIDTH-1:0] y,
    input  logic             data_y_vld,
    output logic             data_y_rdy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             d_out_vld,
    input  logic             d_out_rdy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

    state_t           state;
    logic             run;
    logic             got_x;
    logic             got_y;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             sr;
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] ay;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             x_fire;
    logic             y_fire;
    logic [WIDTH:0]   rs;
    logic             ge;

    // run holds both rdy low until the first clock after reset release
    assign data_x_rdy = run & (state == IDLE) & !got_x;
    assign data_y_rdy = run & (state == IDLE) & !got_y;
    assign x_fire     = data_x_vld & data_x_rdy;
    assign y_fire     = data_y_vld & data_y_rdy;
    assign s          = sr & SIGNED_EN;
    assign rs         = {r, a[WIDTH-1]};
    assign ge         = rs >= {1'b0, ay};

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state       <= IDLE;
            run         <= 1'b0;
            got_x       <= 1'b0;
            got_y       <= 1'b0;
            xr          <= '0;
            yr          <= '0;
            sr          <= 1'b0;
            neg_x       <= 1'b0;
            neg_y       <= 1'b0;
            a           <= '0;
            ay          <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            d_out_vld   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (x_fire) begin
                        xr    <= x;
                        sr    <= sgn;
                        got_x <= 1'b1;
                    end
                    if (y_fire) begin
                        yr    <= y;
                        got_y <= 1'b1;
                    end
                    if ((got_x | x_fire) & (got_y | y_fire))
                        state <= PREP;
                end
                PREP: begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    neg_x       <= s & xr[WIDTH-1];
                    neg_y       <= s & yr[WIDTH-1];
                    a           <= (s & xr[WIDTH-1]) ? -xr : xr;
                    ay          <= (s & yr[WIDTH-1]) ? -yr : yr;
                    r           <= '0;
                    q           <= '0;
                    cnt         <= '0;
                    if (yr == '0) begin
                        quotient    <= '1;
                        remainder   <= xr;
                        div_by_zero <= 1'b1;
                        d_out_vld   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    r   <= ge ? WIDTH'(rs - {1'b0, ay}) : rs[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ge};
                    a   <= a << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    // MIN / -1 yields MIN naturally; only the flag needs raising
                    quotient  <= (neg_x ^ neg_y) ? -q : q;
                    remainder <= neg_x ? -r : r;
                    overflow  <= neg_x & neg_y & (xr == MIN) & (yr == '1);
                    d_out_vld <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (d_out_rdy) begin
                        d_out_vld <= 1'b0;
                        got_x     <= 1'b0;
                        got_y     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div_qr.sv
// Directed bench for serial_div_qr (WIDTH=8, SIGNED_EN=1): results, flags,
// latency, handshake order, backpressure and asynchronous reset mid-iteration.
module tb_serial_div_qr;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic [7:0] x;
    logic       sgn;
    logic       data_x_vld;
    logic       data_x_rdy;
    logic [7:0] y;
    logic       data_y_vld;
    logic       data_y_rdy;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;
    logic       d_out_vld;
    logic       d_out_rdy;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    serial_div_qr #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .x           (x),
        .sgn         (sgn),
        .data_x_vld  (data_x_vld),
        .data_x_rdy  (data_x_rdy),
        .y           (y),
        .data_y_vld  (data_y_vld),
        .data_y_rdy  (data_y_rdy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .d_out_vld   (d_out_vld),
        .d_out_rdy   (d_out_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive both operands in one cycle; returns #1 after the capture edge
    task automatic apply(input logic [7:0] xv, input logic [7:0] yv,
                         input logic sv);
        x = xv;
        y = yv;
        sgn = sv;
        data_x_vld = 1'b1;
        data_y_vld = 1'b1;
        @(posedge clk);
        #1;
        data_x_vld = 1'b0;
        data_y_vld = 1'b0;
    endtask

    // Edges from the capture edge until d_out_vld, bounded at 50
    task automatic wait_vld(output int edges);
        edges = 0;
        while (!d_out_vld && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake(input string tag);
        d_out_rdy = 1'b1;
        @(posedge clk);
        #1;
        d_out_rdy = 1'b0;
        check({tag, " vld drop"}, {31'd0, d_out_vld}, 32'd0);
        check({tag, " rdy back"}, {30'd0, data_x_rdy, data_y_rdy}, 32'd3);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] xv,
                           input logic [7:0] yv, input logic sv,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ez, input logic eo, input int elat);
        apply(xv, yv, sv);
        wait_vld(lat);
        check({tag, " latency"}, lat, elat);
        check({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
        check({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
        check({tag, " flags"}, {30'd0, div_by_zero, overflow},
              {30'd0, ez, eo});
        handshake(tag);
    endtask

    initial begin
        asyn_reset = 1'b0;
        x = '0;
        y = '0;
        sgn = 1'b0;
        data_x_vld = 1'b0;
        data_y_vld = 1'b0;
        d_out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {quotient, remainder, 13'd0, div_by_zero,
              overflow, d_out_vld}, 32'd0);
        asyn_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rdy after reset", {30'd0, data_x_rdy, data_y_rdy}, 32'd3);

        run_vec("unsigned 100/7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2,
                1'b0, 1'b0, 10);
        run_vec("signed -100/7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE,
                1'b0, 1'b0, 10);
        run_vec("signed 100/-7", 8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02,
                1'b0, 1'b0, 10);
        run_vec("div by zero", 8'd37, 8'd0, 1'b0, 8'hFF, 8'd37,
                1'b1, 1'b0, 1);
        run_vec("overflow", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00,
                1'b0, 1'b1, 10);
        run_vec("unsigned FF/1", 8'hFF, 8'd1, 1'b0, 8'hFF, 8'h00,
                1'b0, 1'b0, 10);

        // y first, x three cycles later, with an ignored extra y pulse
        y = 8'd7;
        data_y_vld = 1'b1;
        @(posedge clk);
        #1;
        data_y_vld = 1'b0;
        check("y rdy low", {31'd0, data_y_rdy}, 32'd0);
        check("x rdy high", {31'd0, data_x_rdy}, 32'd1);
        y = 8'd3;
        data_y_vld = 1'b1;
        @(posedge clk);
        #1;
        data_y_vld = 1'b0;
        @(posedge clk);
        #1;
        x = 8'd50;
        sgn = 1'b0;
        data_x_vld = 1'b1;
        @(posedge clk);
        #1;
        data_x_vld = 1'b0;
        wait_vld(lat);
        check("order latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("backpressure", {quotient, remainder, 15'd0, d_out_vld},
                  {8'd7, 8'd1, 15'd0, 1'b1});
        end
        handshake("order");
        check("hold after hs", {16'd0, quotient, remainder},
              {16'd0, 8'd7, 8'd1});

        // back-to-back: captured in the cycle right after the handshake
        run_vec("b2b 9/3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 10);

        // reset when counter=4
        apply(8'd100, 8'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        #2;
        check("mid reset outputs", {quotient, remainder, 11'd0, div_by_zero,
              overflow, d_out_vld, data_x_rdy, data_y_rdy}, 32'd0);
        @(posedge clk);
        #1;
        asyn_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rdy after mid reset", {30'd0, data_x_rdy, data_y_rdy}, 32'd3);
        run_vec("fresh 100/7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2,
                1'b0, 1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
